keypad_driver: RTL
==================

KEYPAD_DRIVER -- requirements
Module: keypad_driver

Interface
REQ-001 Parameter PRESS_CYCLES, default 1048576: clk cycles a key is held pressed; legal range 1..2^24-1.
REQ-002 Parameter RELEASE_CYCLES, default 524288: clk cycles of forced release after each key; legal range 1..2^24-1.
REQ-003 Parameter FIFO_DEPTH, default 4: key-code queue depth; power of two, minimum 2.
REQ-004 clk  input  1  system clock; the single clock; every flop is on its rising edge.
REQ-005 rst  input  1  reset: synchronous, active-low.
REQ-006 key_code  input  4  hex key value 0x0..0xF to press.
REQ-007 key_valid  input  1  key_code is offered this cycle.
REQ-008 key_ready  output  1  queue can accept; a transfer happens when key_valid and key_ready are both high.
REQ-009 col  input  4  column drive from the keypad scanner, active-low.
REQ-010 row  output  4  emulated row return to the scanner, active-low; 4'hF when no key is pressed.
REQ-011 busy  output  1  high when state is not IDLE or the queue is not empty.
REQ-012 key_done  output  1  one-cycle pulse when a key's release phase completes.

Function
REQ-013 Key mapping: column index = key_code[1:0]; row index = key_code[3:2] (0x0 = col0/row0, 0x1 = col1/row0, 0x4 = col0/row1, 0xF = col3/row3).
REQ-014 row shall be combinational from col and the registered press state: in PRESS, row = 4'hF with bit[row index] cleared when col[column index] == 0; otherwise row = 4'hF.
REQ-015 Queue: FIFO_DEPTH entries, first in first out; key_ready = not full; a push while full is impossible because key_ready is low.
REQ-016 FSM states: IDLE, PRESS, RELEASE.
REQ-017 IDLE -> PRESS when the queue was non-empty at the start of the cycle: pop the head into the active-key register and load the counter with PRESS_CYCLES-1.
REQ-018 PRESS: the counter decrements each cycle; at 0 -> RELEASE and load RELEASE_CYCLES-1. PRESS lasts exactly PRESS_CYCLES cycles.
REQ-019 RELEASE: row = 4'hF; the counter decrements each cycle; at 0 -> IDLE and pulse key_done for one cycle. RELEASE lasts exactly RELEASE_CYCLES cycles.
REQ-020 No bypass: a key pushed into an empty queue enters PRESS no earlier than the cycle after the push.
REQ-021 A simultaneous push and pop in the same cycle shall both take effect; the occupancy count is unchanged.
REQ-022 Back-to-back keys: the cycle after key_done, IDLE sees the next queued key, so PRESS starts 1 cycle after RELEASE ends.
REQ-023 Queue pointers wrap modulo FIFO_DEPTH; the occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
REQ-024 The counter is 24 bits, unsigned, and never wraps below 0.

Reset
REQ-025 While rst is low at a clk edge: state = IDLE, counter = 0, queue emptied (pointers and count = 0), active key = 0, key_done = 0.
REQ-026 During and immediately after reset: row = 4'hF, key_ready = 1, busy = 0.
REQ-027 A reset asserted mid-PRESS shall release the key (row = 4'hF) in the same cycle the reset is sampled and discard all queued keys.

Structure
REQ-028 A shared package holds the FSM state encoding, the key-mapping functions (col_idx/row_idx of a 4-bit code), and the 24-bit counter width constant.
REQ-029 The queue is one sub-module, key_fifo: parameterised depth, 4-bit data, push/pop/full/empty, synchronous active-low rst.

Verification (PRESS_CYCLES=8, RELEASE_CYCLES=4, FIFO_DEPTH=4)
REQ-030 Push 0x6, hold col=4'b1011 -> during the 8 PRESS cycles row=4'b1101; with col=4'b1110, row=4'hF; key_done pulses 12 cycles after PRESS entry.
REQ-031 Push 0x0, 0x5, 0xA, 0xF, 0x3 back-to-back -> key_ready drops after the 4th push while the queue is full, or the 5th is accepted if the first pop occurred; emitted order is 0,5,A,F,3 with a 1-cycle IDLE gap between keys.
REQ-032 Connect a behavioural 4-column scanner (col cycling 1110/1101/0111/1011 each cycle) and push 0xD -> row=4'b0111 only while col=4'b1101.
REQ-033 Assert rst low at PRESS cycle 3 with 2 keys queued -> next cycle row=4'hF, busy=0, key_ready=1; no key_done pulse.
REQ-034 Push into an empty queue in the same cycle as the previous key's key_done -> the new key enters PRESS 1 cycle later; occupancy never exceeds 1.

Source files
------------

// File: rtl/keypad_driver_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_driver_pkg : FSM encoding, counter width and key-mapping helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package keypad_driver_pkg;

   localparam int CNT_W = 24;
   localparam int KEY_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESS   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   function automatic logic [1:0] col_idx(input logic [KEY_W-1:0] code);
      return code[1:0];
   endfunction

   function automatic logic [1:0] row_idx(input logic [KEY_W-1:0] code);
      return code[3:2];
   endfunction

   // Active-low one-cold row pattern for a given row index.
   function automatic logic [3:0] row_mask(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_fifo : small FIFO of key codes with occupancy-based full/empty
// Rev 1.0
// ---------------------------------------------------------------------------
module key_fifo
   import keypad_driver_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [KEY_W-1:0] push_data,
   input  logic             pop,
   output logic [KEY_W-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [KEY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst && do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (count == (PTR_W + 1)'(DEPTH));
   assign empty    = (count == '0);

endmodule
`default_nettype wire

// File: rtl/keypad_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_driver : emulates key presses on a scanned 4x4 matrix from a queue
// Rev 1.0
// ---------------------------------------------------------------------------
module keypad_driver
   import keypad_driver_pkg::*;
#(
   parameter int PRESS_CYCLES   = 1048576,
   parameter int RELEASE_CYCLES = 524288,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_code,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic [3:0]       col,
   output logic [3:0]       row,
   output logic             busy,
   output logic             key_done
);

   localparam logic [CNT_W-1:0] PRESS_LOAD   = CNT_W'(PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [KEY_W-1:0] active_key;
   logic [KEY_W-1:0] active_nxt;
   logic             done_nxt;
   logic             pop;
   logic             push;
   logic             fifo_full;
   logic             fifo_empty;
   logic [KEY_W-1:0] head;

   assign push = key_valid & key_ready;

   key_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_key_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (key_code),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         count      <= '0;
         active_key <= '0;
         key_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         active_key <= active_nxt;
         key_done   <= done_nxt;
      end
   end

   // The pop decision uses the registered empty flag, so a key pushed this
   // cycle is only seen by IDLE on the following cycle.
   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      active_nxt = active_key;
      done_nxt   = 1'b0;
      pop        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               active_nxt = head;
               count_nxt  = PRESS_LOAD;
               state_nxt  = ST_PRESS;
            end
         end
         ST_PRESS: begin
            if (count == '0) begin
               count_nxt = RELEASE_LOAD;
               state_nxt = ST_RELEASE;
            end else begin
               count_nxt = count - 1'b1;
            end
         end
         ST_RELEASE: begin
            if (count == '0) begin
               done_nxt  = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               count_nxt = count - 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are forced to their idle values while reset is asserted so the
   // key is released in the very cycle reset is applied.
   always_comb begin
      row = 4'hF;
      if (rst && (state == ST_PRESS) && (col[col_idx(active_key)] == 1'b0)) begin
         row = row_mask(row_idx(active_key));
      end
   end

   assign key_ready = ~rst | ~fifo_full;
   assign busy      = rst & ((state != ST_IDLE) | ~fifo_empty);

endmodule
`default_nettype wire
